// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b alignment definitions: aligner states, comma patterns and the
// comma match helper used on the 10-bit sliding window.
package enc8b10b_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        SYNC  = 2'd2
    } state_t;

    localparam int          SYM_W      = 10;
    localparam logic [6:0]  COMMA_P    = 7'b0011111;
    localparam logic [6:0]  COMMA_N    = 7'b1100000;
    localparam logic [3:0]  PHASE_LAST = 4'd9;

    // The seven oldest window bits (abcdeif) carry the comma signature.
    function automatic logic comma_hit(input logic [SYM_W-1:0] w);
        return (w[9:3] == COMMA_P) || (w[9:3] == COMMA_N);
    endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Serial-in / aligned-symbol-out bundle of the comma aligner; the line side
// (master) drives bits, the aligner (slave) drives symbols and status.
interface comma_aligner_if;
    import enc8b10b_pkg::*;

    logic             bit_in;
    logic             bit_valid;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             is_comma;
    logic             rd_sym;
    logic             disp_err;
    logic             locked;

    modport master (
        output bit_in, bit_valid,
        input  sym_out, sym_valid, is_comma, rd_sym, disp_err, locked
    );

    modport slave (
        input  bit_in, bit_valid,
        output sym_out, sym_valid, is_comma, rd_sym, disp_err, locked
    );

endinterface

// File: rtl/comma_aligner_rd_tracker.sv
// Running-disparity tracker: counts ones of each emitted symbol, reports the
// disparity the symbol entered with, and flags out-of-range weights.
module rd_tracker
    import enc8b10b_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym,
    input  logic             emit,
    output logic             rd_sym,
    output logic             disp_err
);

    logic [3:0] ones;
    logic       rd_q, rd_d;
    logic       rd_sym_q, rd_sym_d;
    logic       disp_err_q, disp_err_d;

    always_comb begin
        ones = '0;
        for (int i = 0; i < SYM_W; i++) begin
            ones = ones + 4'(sym[i]);
        end
    end

    // A balanced symbol (five ones) leaves the running disparity untouched.
    always_comb begin
        rd_d       = rd_q;
        rd_sym_d   = rd_sym_q;
        disp_err_d = disp_err_q;
        if (emit) begin
            rd_sym_d   = rd_q;
            disp_err_d = (ones < 4'd4) || (ones > 4'd6);
            if (ones > 4'd5) begin
                rd_d = 1'b1;
            end else if (ones < 4'd5) begin
                rd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= 1'b0;
            rd_sym_q   <= 1'b0;
            disp_err_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            rd_sym_q   <= rd_sym_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign rd_sym   = rd_sym_q;
    assign disp_err = disp_err_q;

endmodule

// File: rtl/comma_aligner.sv
// Serial 10-bit symbol aligner: hunts for a comma, confirms SYNC_COMMAS
// aligned commas before locking, and drops lock after LOSS_MISS misplaced ones.
module comma_aligner
    import enc8b10b_pkg::*;
#(
    parameter int SYNC_COMMAS = 3,
    parameter int LOSS_MISS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    comma_aligner_if.slave        bus
);

    localparam int CC_W = $clog2(SYNC_COMMAS + 1);
    localparam int MC_W = $clog2(LOSS_MISS + 1);

    state_t           state_q, state_d;
    logic [8:0]       sr_q, sr_d;
    logic [3:0]       phase_q, phase_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [SYM_W-1:0] sym_out_q, sym_out_d;
    logic             sym_valid_q, sym_valid_d;
    logic             is_comma_q, is_comma_d;

    logic [SYM_W-1:0] win;
    logic             comma;
    logic             at_bnd;
    logic             emit;

    assign win    = {sr_q, bus.bit_in};
    assign comma  = comma_hit(win);
    assign at_bnd = (phase_q == PHASE_LAST);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        phase_d     = phase_q;
        comma_cnt_d = comma_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        emit        = 1'b0;

        if (bus.bit_valid) begin
            sr_d = win[8:0];
            if (state_q == HUNT) begin
                if (comma) begin
                    emit        = 1'b1;
                    phase_d     = '0;
                    comma_cnt_d = CC_W'(1);
                    state_d     = CHECK;
                end
            end else begin
                if (at_bnd) begin
                    emit    = 1'b1;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end

                // A misplaced comma while confirming means the first one was a false hit.
                if (comma && state_q == CHECK) begin
                    if (at_bnd) begin
                        comma_cnt_d = comma_cnt_q + CC_W'(1);
                        if (comma_cnt_d == CC_W'(SYNC_COMMAS)) begin
                            state_d    = SYNC;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end else if (comma && state_q == SYNC) begin
                    if (at_bnd) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MC_W'(1);
                        if (miss_cnt_d == MC_W'(LOSS_MISS)) begin
                            state_d = HUNT;
                            phase_d = '0;
                        end
                    end
                end
            end
        end

        sym_valid_d = emit;
        sym_out_d   = emit ? win   : sym_out_q;
        is_comma_d  = emit ? comma : is_comma_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            phase_q     <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            is_comma_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            phase_q     <= phase_d;
            comma_cnt_q <= comma_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            is_comma_q  <= is_comma_d;
        end
    end

    rd_tracker u_rd_tracker (
        .clk      (clk),
        .reset    (reset),
        .sym      (win),
        .emit     (emit),
        .rd_sym   (bus.rd_sym),
        .disp_err (bus.disp_err)
    );

    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.is_comma  = is_comma_q;
    assign bus.locked    = (state_q == SYNC);

endmodule

// File: doc/comma_aligner.md
COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 Parameter SYNC_COMMAS, default 3: aligned commas needed to declare lock.
REQ-002 Parameter LOSS_MISS, default 4: consecutive misaligned commas that drop lock.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bit_in  input  1  serial line bit, transmission order a,b,c,d,e,i,f,g,h,j.
REQ-006 bit_valid  input  1  bit_in is sampled only in cycles where this is high.
REQ-007 sym_out  output  10  aligned symbol; [9:4]=abcdei, [3:0]=fghj (the fghj nibble feeds the 4b/3b decoder).
REQ-008 sym_valid  output  1  one-cycle pulse; sym_out, is_comma, rd_sym and disp_err are valid in that cycle.
REQ-009 is_comma  output  1  sym_out carries a comma.
REQ-010 rd_sym  output  1  running disparity entering sym_out; 0 = negative, 1 = positive; drives the decoder disparity input.
REQ-011 disp_err  output  1  sym_out ones-count is not 4, 5 or 6.
REQ-012 locked  output  1  high only in state SYNC.

Function
REQ-013 Shift register sr[8:0] updates only on bit_valid, as sr <= {sr[7:0], bit_in}.
REQ-014 Window w = {sr[8:0], bit_in} is evaluated only on bit_valid cycles.
REQ-015 Comma is detected when w[9:3] equals 0011111 or 1100000.
REQ-016 A 4-bit phase counter counts bits of the current symbol, 0..9.
REQ-017 States: HUNT, CHECK and SYNC; miss_cnt and comma_cnt are each sized to their parameter.
REQ-018 HUNT: on a comma, emit w as a symbol, set phase to 0, set comma_cnt to 1 and go to CHECK; no other HUNT cycle emits.
REQ-019 CHECK/SYNC, any bit_valid cycle: if phase is 9, emit w and set phase to 0; otherwise increment phase.
REQ-020 CHECK, comma at phase 9: increment comma_cnt; on reaching SYNC_COMMAS, go to SYNC and clear miss_cnt.
REQ-021 CHECK, comma at phase other than 9: go to HUNT; no symbol is emitted that cycle.
REQ-022 SYNC, comma at phase 9: clear miss_cnt.
REQ-023 SYNC, comma at phase other than 9: increment miss_cnt; on reaching LOSS_MISS, go to HUNT with phase 0.
REQ-024 SYNC, symbol with no comma: miss_cnt is unchanged.
REQ-025 Emit timing: sym_out, sym_valid and is_comma are registered and appear the cycle after the bit_valid cycle that completed w.
REQ-026 rd_sym on emit is the current rd register value.
REQ-027 rd update on emit: ones(w) > 5 sets rd to 1; ones(w) < 5 sets rd to 0; ones(w) = 5 leaves rd unchanged.
REQ-028 disp_err asserts with the symbol when ones(w) is not in {4, 5, 6}; rd still updates per REQ-027.
REQ-029 When bit_valid is low, all state holds and sym_valid is 0.
REQ-030 Outputs other than sym_valid hold their last value between emits.
REQ-031 Transition from SYNC to HUNT deasserts locked in the next cycle.

Reset
REQ-032 reset has priority over bit_valid.
REQ-033 Reset values: state HUNT, sr 0, phase 0, comma_cnt 0, miss_cnt 0, rd 0.
REQ-034 Reset values: sym_out 0, sym_valid 0, is_comma 0, rd_sym 0, disp_err 0, locked 0.
REQ-035 Reset asserted mid-symbol or mid-lock discards the partial symbol and emits nothing in the following cycle.

Structure
REQ-036 Shared package enc8b10b_pkg holds the state enum (HUNT, CHECK, SYNC) and the constants COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000.
REQ-037 One sub-module, rd_tracker, holds the ones-count, the rd register and the disp_err logic.

Verification
REQ-038 After reset, send K28.5- (0011111010) three times back-to-back -> three sym_valid pulses, each with is_comma=1; locked rises the cycle after the third.
REQ-039 Send 3 random bits, then K28.5-, K28.5+ (1100000101), K28.5- -> lock is reached; sym_out is 0011111010, 1100000101, 0011111010 and rd_sym is 0, 1, 0.
REQ-040 While locked, insert a comma shifted by 2 bits four times with no aligned comma between -> locked falls after the fourth; one aligned comma in between restores miss_cnt to 0 and lock holds.
REQ-041 While locked, send 1111111010 -> disp_err=1 and the next rd_sym is 1.
REQ-042 Toggle bit_valid low for random gaps during a lock sequence -> output is identical to the gapless run apart from timing.
REQ-043 Assert reset mid-symbol while locked -> no sym_valid next cycle, locked=0, state HUNT; re-lock takes exactly SYNC_COMMAS commas.
